hsaf_coef_reader: RTL and testbench

Readout unit for the adaptive filter's learned state. On request it captures a one-cycle snapshot of all linear FIR weights and all spline control points (q-table) into shadow registers. It then serialises them out, one word per accepted transfer, over a valid/ready stream. It sits beside the hsaflms/q_weight_controller datapath as the reader side of the coefficient update path: the filter writes coefficients, and this block reads them out for host or debug capture without stalling adaptation.

---
 rtl/hsaf_coef_reader.sv | 195 +++++++++++++++++++
 tb/tb_hsaf_coef_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hsaf_coef_reader.sv
// Coefficient readout: snapshots FIR weights and spline q-table, then streams them over valid/ready.
// Optional trailing checksum word is enabled by defining HSAF_COEF_CKSUM_EN.
module hsaf_coef_reader #(
  parameter int L_ORD = 32,
  parameter int Q     = 13,
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(((L_ORD > Q) ? L_ORD : Q) + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   snap_req,
  input  logic [L_ORD*WIDTH-1:0] weight_packed,
  input  logic [Q*WIDTH-1:0]     q_table_packed,
  output logic [WIDTH-1:0]       out_data,
  output logic [1:0]             out_type,
  output logic [IDX_W-1:0]       out_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   snap_drop
);

  localparam logic [1:0] T_W = 2'b00;
  localparam logic [1:0] T_Q = 2'b01;

`ifdef HSAF_COEF_CKSUM_EN
  localparam logic [1:0] T_C = 2'b10;
  localparam bit CKSUM_EN = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_STREAM_W, S_STREAM_Q, S_STREAM_C} state_t;
`else
  localparam bit CKSUM_EN = 1'b0;
  typedef enum logic [1:0] {S_IDLE, S_STREAM_W, S_STREAM_Q} state_t;
`endif

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic [1:0]             out_type_q, out_type_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   snap_drop_q, snap_drop_d;
  logic [L_ORD*WIDTH-1:0] shadow_w_q, shadow_w_d;
  logic [Q*WIDTH-1:0]     shadow_c_q, shadow_c_d;
`ifdef HSAF_COEF_CKSUM_EN
  logic [WIDTH-1:0]       sum_q, sum_d;
`endif

  logic                   xfer;
  logic [IDX_W-1:0]       idx_inc;

  assign xfer    = out_valid_q && out_ready;
  assign idx_inc = idx_q + 1'b1;

  // NOTE: every *_d gets its current value first, so a path that assigns nothing holds state instead of inferring a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_type_d  = out_type_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    shadow_w_d  = shadow_w_q;
    shadow_c_d  = shadow_c_q;
`ifdef HSAF_COEF_CKSUM_EN
    sum_d       = sum_q;
`endif
    snap_drop_d = snap_req && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (snap_req) begin
          // First word comes straight from the live bus; it is the same value the shadow captures.
          shadow_w_d  = weight_packed;
          shadow_c_d  = q_table_packed;
          state_d     = S_STREAM_W;
          idx_d       = '0;
          out_data_d  = weight_packed[0 +: WIDTH];
          out_type_d  = T_W;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
`ifdef HSAF_COEF_CKSUM_EN
          sum_d       = '0;
`endif
        end
      end

      S_STREAM_W: begin
        if (xfer) begin
`ifdef HSAF_COEF_CKSUM_EN
          sum_d = sum_q + out_data_q;
`endif
          if (idx_q == IDX_W'(L_ORD - 1)) begin
            state_d    = S_STREAM_Q;
            idx_d      = '0;
            out_data_d = shadow_c_q[0 +: WIDTH];
            out_type_d = T_Q;
            out_last_d = (Q == 1) && !CKSUM_EN;
          end else begin
            idx_d      = idx_inc;
            out_data_d = shadow_w_q[WIDTH*idx_inc +: WIDTH];
          end
        end
      end

      S_STREAM_Q: begin
        if (xfer) begin
`ifdef HSAF_COEF_CKSUM_EN
          sum_d = sum_q + out_data_q;
`endif
          if (idx_q == IDX_W'(Q - 1)) begin
`ifdef HSAF_COEF_CKSUM_EN
            state_d    = S_STREAM_C;
            idx_d      = '0;
            out_data_d = sum_q + out_data_q;
            out_type_d = T_C;
            out_last_d = 1'b1;
`else
            state_d     = S_IDLE;
            idx_d       = '0;
            out_data_d  = '0;
            out_type_d  = T_W;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
`endif
          end else begin
            idx_d      = idx_inc;
            out_data_d = shadow_c_q[WIDTH*idx_inc +: WIDTH];
            out_last_d = (idx_inc == IDX_W'(Q - 1)) && !CKSUM_EN;
          end
        end
      end

`ifdef HSAF_COEF_CKSUM_EN
      S_STREAM_C: begin
        if (xfer) begin
          state_d     = S_IDLE;
          idx_d       = '0;
          out_data_d  = '0;
          out_type_d  = T_W;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
`endif

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_type_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      snap_drop_q <= 1'b0;
      // NOTE: shadow registers are cleared on reset so no stale coefficients survive; this costs a reset on every shadow bit.
      shadow_w_q  <= '0;
      shadow_c_q  <= '0;
`ifdef HSAF_COEF_CKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_type_q  <= out_type_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      snap_drop_q <= snap_drop_d;
      shadow_w_q  <= shadow_w_d;
      shadow_c_q  <= shadow_c_d;
`ifdef HSAF_COEF_CKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_type  = out_type_q;
  assign out_index = idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);
  assign snap_drop = snap_drop_q;

endmodule

// File: tb/tb_hsaf_coef_reader.sv
// Self-checking bench for hsaf_coef_reader: queue-based snapshot model plus directed literal checks.
module tb_hsaf_coef_reader;

  localparam int L_ORD = 32;
  localparam int Q     = 13;
  localparam int WIDTH = 16;
  localparam int IDX_W = 6;
`ifdef HSAF_COEF_CKSUM_EN
  localparam bit CK = 1'b1;
  localparam int N_WORDS = L_ORD + Q + 1;
`else
  localparam bit CK = 1'b0;
  localparam int N_WORDS = L_ORD + Q;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   snap_req = 1'b0;
  logic [L_ORD*WIDTH-1:0] weight_packed = '0;
  logic [Q*WIDTH-1:0]     q_table_packed = '0;
  logic [WIDTH-1:0]       out_data;
  logic [1:0]             out_type;
  logic [IDX_W-1:0]       out_index;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic                   out_last;
  logic                   busy;
  logic                   snap_drop;

  hsaf_coef_reader dut (
    .clk(clk), .reset(reset), .snap_req(snap_req),
    .weight_packed(weight_packed), .q_table_packed(q_table_packed),
    .out_data(out_data), .out_type(out_type), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .snap_drop(snap_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a snapshot is simply the ordered list of words the stream must carry.
  typedef struct {
    logic [WIDTH-1:0] data;
    logic [1:0]       typ;
    logic [IDX_W-1:0] idx;
    logic             last;
  } word_t;

  word_t exp_q[$];
  bit    m_busy  = 1'b0;
  bit    m_drop  = 1'b0;
  bit    started = 1'b0;

  always @(posedge clk) begin
    bit b;
    started = 1'b1;
    if (reset) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_drop = 1'b0;
    end else begin
      b = m_busy;
      m_drop = snap_req && b;
      if (b && out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_busy = 1'b0;
      end
      if (snap_req && !b) begin
        int sum = 0;
        for (int i = 0; i < L_ORD; i++) begin
          exp_q.push_back('{weight_packed[WIDTH*i +: WIDTH], 2'd0, IDX_W'(i), 1'b0});
          sum += int'(weight_packed[WIDTH*i +: WIDTH]);
        end
        for (int j = 0; j < Q; j++) begin
          exp_q.push_back('{q_table_packed[WIDTH*j +: WIDTH], 2'd1, IDX_W'(j), (j == Q - 1) && !CK});
          sum += int'(q_table_packed[WIDTH*j +: WIDTH]);
        end
        if (CK) exp_q.push_back('{WIDTH'(sum % 65536), 2'd2, '0, 1'b1});
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("snap_drop", {31'd0, snap_drop}, {31'd0, m_drop});
      if (exp_q.size() != 0) begin
        check("data", {16'd0, out_data}, {16'd0, exp_q[0].data});
        check("type", {30'd0, out_type}, {30'd0, exp_q[0].typ});
        check("index", {26'd0, out_index}, {26'd0, exp_q[0].idx});
        check("last", {31'd0, out_last}, {31'd0, exp_q[0].last});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load_basic();
    for (int i = 0; i < L_ORD; i++) weight_packed[WIDTH*i +: WIDTH] = 16'h0100 + 16'(i);
    for (int j = 0; j < Q; j++) q_table_packed[WIDTH*j +: WIDTH] = 16'h1000 + 16'(j);
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
  endtask

  task automatic wait_data(input logic [WIDTH-1:0] d, input string name);
    int c = 0;
    while (!(out_valid && out_data == d) && c < 100) begin
      step();
      c++;
    end
    check(name, {15'd0, out_valid, out_data}, {15'd0, 1'b1, d});
  endtask

  task automatic drain(input string name);
    int c = 0;
    out_ready = 1'b1;
    while (busy && c < 200) begin
      step();
      c++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] l_data;
    logic [1:0] l_type;
    logic [IDX_W-1:0] l_idx;
    logic l_last, q12_last;

    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_type", {30'd0, out_type}, 32'd0);
    check("rst_index", {26'd0, out_index}, 32'd0);
    check("rst_flags", {28'd0, out_valid, out_last, busy, snap_drop}, 32'd0);

    // Basic stream
    load_basic();
    pulse_snap();
    check("first_word", {out_valid, out_type, out_index, out_data}, {1'b1, 2'b00, 6'd0, 16'h0100});
    n = 0; q12_last = 1'bx; l_data = '0; l_type = '0; l_idx = '0; l_last = 1'b0;
    for (int c = 0; c < 200 && busy; c++) begin
      if (out_valid && out_ready) begin
        n++;
        l_data = out_data; l_type = out_type; l_idx = out_index; l_last = out_last;
        if (out_type == 2'b01 && out_index == 6'd12) q12_last = out_last;
      end
      step();
    end
    check("basic_done", {31'd0, busy}, 32'd0);
    check("word_count", n, N_WORDS);
`ifdef HSAF_COEF_CKSUM_EN
    check("q12_last", {31'd0, q12_last}, 32'd0);
    check("cksum_word", {l_last, l_type, l_idx, l_data}, {1'b1, 2'b10, 6'd0, 16'hF23E});
`else
    check("last_word", {l_last, l_type, l_idx, l_data}, {1'b1, 2'b01, 6'd12, 16'h100C});
`endif
    step();
    check("idle_after", {30'd0, out_valid, busy}, 32'd0);

    // Backpressure
    pulse_snap();
    wait_data(16'h0105, "bp_reach");
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold", {out_valid, out_index, out_data}, {1'b1, 6'd5, 16'h0105});
    end
    out_ready = 1'b1;
    step();
    check("bp_next", {out_index, out_data}, {6'd6, 16'h0106});
    drain("bp_drain");

    // Snapshot isolation and drop
    pulse_snap();
    wait_data(16'h010A, "iso_reach");
    weight_packed = '1;
    q_table_packed = '1;
    pulse_snap();
    check("iso_drop", {31'd0, snap_drop}, 32'd1);
    check("iso_data", {16'd0, out_data}, {16'd0, 16'h010B});
    step();
    check("iso_drop_end", {31'd0, snap_drop}, 32'd0);
    drain("iso_drain");
    repeat (4) step();
    check("iso_no_second", {30'd0, out_valid, busy}, 32'd0);
    load_basic();

    // Reset mid-stream
    pulse_snap();
    wait_data(16'h010A, "rst_reach");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst", {out_valid, busy, out_last, out_data}, 32'd0);
    pulse_snap();
    check("restart", {out_valid, out_index, out_data}, {1'b1, 6'd0, 16'h0100});
    drain("rst_drain");

    // Type boundary with backpressure
    pulse_snap();
    wait_data(16'h011F, "tb_reach");
    out_ready = 1'b0;
    repeat (2) begin
      step();
      check("tb_hold", {out_valid, out_type, out_index, out_data}, {1'b1, 2'b00, 6'd31, 16'h011F});
    end
    out_ready = 1'b1;
    step();
    check("tb_q0", {out_valid, out_type, out_index, out_data}, {1'b1, 2'b01, 6'd0, 16'h1000});
    step();
    check("tb_q1", {out_type, out_index, out_data}, {2'b01, 6'd1, 16'h1001});

    // snap_req on the edge that transfers the final word
    begin
      int c = 0;
      while (!(out_valid && out_last) && c < 100) begin
        step();
        c++;
      end
      check("final_reach", {31'd0, out_last}, 32'd1);
    end
    pulse_snap();
    check("final_drop", {29'd0, snap_drop, busy, out_valid}, {29'd0, 3'b100});
    step();
    check("final_idle", {29'd0, snap_drop, busy, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
